// File: rtl/simon_pkg.sv
// Shared mode encodings and default sizing for the Simon datapath blocks.
package simon_pkg;

  localparam logic [2:0] MODE_IDLE     = 3'd0;
  localparam logic [2:0] MODE_INPUT    = 3'd1;
  localparam logic [2:0] MODE_PLAYBACK = 3'd2;
  localparam logic [2:0] MODE_REPEAT   = 3'd3;
  localparam logic [2:0] MODE_DONE     = 3'd4;

  localparam int DEF_COLORS = 4;
  localparam int DEF_DEPTH  = 64;

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence storage: synchronous write, asynchronous read, contents survive reset.
module simon_seq_mem #(
  parameter int COLORS = 4,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [COLORS-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [COLORS-1:0] rdata
);

  logic [COLORS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simon_datapath_param.sv
// Simon datapath: records the player's colour sequence and paces it out for
// playback, repeat checking and looping end-of-game replay.
module simon_datapath_param
  import simon_pkg::*;
#(
  parameter int COLORS = DEF_COLORS,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   level,
  input  logic [COLORS-1:0]      pattern,
  input  logic [2:0]             mode,
  input  logic                   step,
  input  logic                   clrcount,
  input  logic                   w_en,
  output logic                   is_legal,
  output logic                   play_eq_count,
  output logic                   repeat_eq_play,
  output logic                   input_eq_pattern,
  output logic                   seq_full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count,
  output logic [COLORS-1:0]      pattern_leds
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]       play_ptr;
  logic [AW:0]       rep_ptr;
  logic [AW:0]       done_ptr;
  logic [AW:0]       done_next;
  logic [AW:0]       rd_ptr;
  logic [COLORS-1:0] rd_data;
  logic              mem_we;

  // Read port follows whichever pointer the current mode is walking.
  always_comb begin
    rd_ptr = '0;
    case (mode)
      MODE_PLAYBACK: rd_ptr = play_ptr;
      MODE_REPEAT:   rd_ptr = rep_ptr;
      MODE_DONE:     rd_ptr = done_ptr;
      default:       rd_ptr = '0;
    endcase
  end

  assign seq_full         = (count == DEPTH_C);
  assign mem_we           = (mode == MODE_INPUT) && w_en && !seq_full && !clrcount;
  assign done_next        = done_ptr + 1'b1;
  assign is_legal         = (|pattern) && (level || $onehot(pattern));
  assign play_eq_count    = (play_ptr == count);
  assign repeat_eq_play   = (rep_ptr == count);
  assign input_eq_pattern = (pattern == rd_data);

  simon_seq_mem #(
    .COLORS(COLORS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(count[AW-1:0]),
    .wdata(pattern),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_data)
  );

  // clrcount wipes all bookkeeping but leaves the stored colours alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      play_ptr     <= '0;
      rep_ptr      <= '0;
      done_ptr     <= '0;
      pattern_leds <= '0;
      overflow     <= 1'b0;
    end else if (clrcount) begin
      count        <= '0;
      play_ptr     <= '0;
      rep_ptr      <= '0;
      done_ptr     <= '0;
      pattern_leds <= '0;
      overflow     <= 1'b0;
    end else begin
      case (mode)
        MODE_INPUT: begin
          pattern_leds <= pattern;
          play_ptr     <= '0;
          if (w_en) begin
            if (seq_full) overflow <= 1'b1;
            else          count    <= count + 1'b1;
          end
        end
        MODE_PLAYBACK: begin
          rep_ptr <= '0;
          if (step && (play_ptr < count)) begin
            pattern_leds <= rd_data;
            play_ptr     <= play_ptr + 1'b1;
          end
        end
        MODE_REPEAT: begin
          pattern_leds <= pattern;
          done_ptr     <= '0;
          if (step && (rep_ptr < count)) rep_ptr <= rep_ptr + 1'b1;
        end
        MODE_DONE: begin
          // Replay loops forever so the final sequence keeps flashing.
          if (count == '0) begin
            pattern_leds <= '0;
          end else if (step) begin
            pattern_leds <= rd_data;
            done_ptr     <= (done_next == count) ? '0 : done_next;
          end
        end
        MODE_IDLE: pattern_leds <= '0;
        default:   pattern_leds <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_datapath_param.sv
// Directed self-checking bench for simon_datapath_param (DEPTH=64 and DEPTH=4 instances).
module tb_simon_datapath_param;
  import simon_pkg::*;

  logic       clk;
  logic       rst;
  logic       level;
  logic [3:0] pattern;
  logic [2:0] mode;
  logic       step;
  logic       clrcount;
  logic       w_en;

  logic       is_legal, play_eq_count, repeat_eq_play, input_eq_pattern, seq_full, overflow;
  logic [6:0] count;
  logic [3:0] pattern_leds;

  logic       is_legal4, play_eq_count4, repeat_eq_play4, input_eq_pattern4, seq_full4, overflow4;
  logic [2:0] count4;
  logic [3:0] pattern_leds4;

  int total;
  int bad;

  simon_datapath_param #(.COLORS(4), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .level(level), .pattern(pattern), .mode(mode),
    .step(step), .clrcount(clrcount), .w_en(w_en),
    .is_legal(is_legal), .play_eq_count(play_eq_count), .repeat_eq_play(repeat_eq_play),
    .input_eq_pattern(input_eq_pattern), .seq_full(seq_full), .overflow(overflow),
    .count(count), .pattern_leds(pattern_leds)
  );

  simon_datapath_param #(.COLORS(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .level(level), .pattern(pattern), .mode(mode),
    .step(step), .clrcount(clrcount), .w_en(w_en),
    .is_legal(is_legal4), .play_eq_count(play_eq_count4), .repeat_eq_play(repeat_eq_play4),
    .input_eq_pattern(input_eq_pattern4), .seq_full(seq_full4), .overflow(overflow4),
    .count(count4), .pattern_leds(pattern_leds4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] m, input logic [3:0] p,
                               input logic w, input logic s, input logic c);
    mode     = m;
    pattern  = p;
    w_en     = w;
    step     = s;
    clrcount = c;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; level = 1'b0; pattern = 4'b0000; mode = MODE_IDLE;
    step = 1'b0; clrcount = 1'b0; w_en = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_leds", 32'(pattern_leds), 32'h0);
    checkOutput("rst_play_eq", 32'(play_eq_count), 32'd1);
    checkOutput("rst_rep_eq", 32'(repeat_eq_play), 32'd1);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_count4", 32'(count4), 32'd0);
    checkOutput("rst_full4", 32'(seq_full4), 32'd0);
    #9 rst = 1'b1;

    // Legality
    level = 1'b0; pattern = 4'b0011; #1;
    checkOutput("legal_l0_0011", 32'(is_legal), 32'd0);
    pattern = 4'b0100; #1;
    checkOutput("legal_l0_0100", 32'(is_legal), 32'd1);
    pattern = 4'b0000; #1;
    checkOutput("legal_l0_0000", 32'(is_legal), 32'd0);
    level = 1'b1; pattern = 4'b0011; #1;
    checkOutput("legal_l1_0011", 32'(is_legal), 32'd1);
    pattern = 4'b0000; #1;
    checkOutput("legal_l1_0000", 32'(is_legal), 32'd0);
    level = 1'b0;

    // Build a sequence, start playback, then async reset mid-cycle
    tick();
    applyStimulus(MODE_INPUT, 4'b0010, 1'b1, 1'b0, 1'b0);
    applyStimulus(MODE_INPUT, 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(MODE_INPUT, 4'b0100, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_count", 32'(count), 32'd3);
    checkOutput("t1_full", 32'(seq_full), 32'd0);
    applyStimulus(MODE_PLAYBACK, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_led0", 32'(pattern_leds), 32'h2);
    #2 rst = 1'b0;
    #1;
    checkOutput("t1_rst_count", 32'(count), 32'd0);
    checkOutput("t1_rst_leds", 32'(pattern_leds), 32'h0);
    checkOutput("t1_rst_play_eq", 32'(play_eq_count), 32'd1);
    checkOutput("t1_rst_ovf", 32'(overflow), 32'd0);
    #2 rst = 1'b1;

    // Input 0001,0100,1000 then playback
    applyStimulus(MODE_INPUT, 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(MODE_INPUT, 4'b0100, 1'b1, 1'b0, 1'b0);
    applyStimulus(MODE_INPUT, 4'b1000, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_count", 32'(count), 32'd3);
    checkOutput("t2_input_leds", 32'(pattern_leds), 32'h8);
    applyStimulus(MODE_PLAYBACK, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_led0", 32'(pattern_leds), 32'h1);
    checkOutput("t2_play_eq0", 32'(play_eq_count), 32'd0);
    applyStimulus(MODE_PLAYBACK, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_led1", 32'(pattern_leds), 32'h4);
    applyStimulus(MODE_PLAYBACK, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_led2", 32'(pattern_leds), 32'h8);
    checkOutput("t2_play_eq3", 32'(play_eq_count), 32'd1);
    applyStimulus(MODE_PLAYBACK, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_led_hold", 32'(pattern_leds), 32'h8);

    // Repeat checking
    mode = MODE_REPEAT; step = 1'b0; pattern = 4'b0001; #1;
    checkOutput("t3_eq_match", 32'(input_eq_pattern), 32'd1);
    pattern = 4'b0010; #1;
    checkOutput("t3_eq_miss", 32'(input_eq_pattern), 32'd0);
    applyStimulus(MODE_REPEAT, 4'b0001, 1'b0, 1'b1, 1'b0);
    step = 1'b0; pattern = 4'b0100; #1;
    checkOutput("t3_eq_idx1", 32'(input_eq_pattern), 32'd1);
    checkOutput("t3_rep_eq_mid", 32'(repeat_eq_play), 32'd0);
    applyStimulus(MODE_REPEAT, 4'b0100, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_rep_leds", 32'(pattern_leds), 32'h4);
    applyStimulus(MODE_REPEAT, 4'b1000, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_rep_eq_end", 32'(repeat_eq_play), 32'd1);
    applyStimulus(MODE_REPEAT, 4'b1000, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_rep_sat", 32'(repeat_eq_play), 32'd1);

    // Looping DONE replay with count=2
    applyStimulus(MODE_IDLE, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_clr_count", 32'(count), 32'd0);
    applyStimulus(MODE_INPUT, 4'b0110, 1'b1, 1'b0, 1'b0);
    applyStimulus(MODE_INPUT, 4'b1001, 1'b1, 1'b0, 1'b0);
    applyStimulus(MODE_REPEAT, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(MODE_DONE, 4'b0000, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_done0", 32'(pattern_leds), 32'h6);
    applyStimulus(MODE_DONE, 4'b0000, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_done1", 32'(pattern_leds), 32'h9);
    applyStimulus(MODE_DONE, 4'b0000, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_done2", 32'(pattern_leds), 32'h6);
    applyStimulus(MODE_DONE, 4'b0000, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_done3", 32'(pattern_leds), 32'h9);
    applyStimulus(MODE_DONE, 4'b0000, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_done4", 32'(pattern_leds), 32'h6);
    checkOutput("t6_wen_ignored", 32'(count), 32'd2);
    applyStimulus(MODE_IDLE, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(MODE_INPUT, 4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_pre_leds", 32'(pattern_leds), 32'hF);
    applyStimulus(MODE_DONE, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t6_empty_leds", 32'(pattern_leds), 32'h0);

    // Overflow on the DEPTH=4 instance
    applyStimulus(MODE_IDLE, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(MODE_INPUT, 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(MODE_INPUT, 4'b0010, 1'b1, 1'b0, 1'b0);
    applyStimulus(MODE_INPUT, 4'b0100, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_full3", 32'(seq_full4), 32'd0);
    applyStimulus(MODE_INPUT, 4'b1000, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_count4", 32'(count4), 32'd4);
    checkOutput("t5_full4", 32'(seq_full4), 32'd1);
    checkOutput("t5_ovf_pre", 32'(overflow4), 32'd0);
    applyStimulus(MODE_INPUT, 4'b1111, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_count_hold", 32'(count4), 32'd4);
    checkOutput("t5_ovf", 32'(overflow4), 32'd1);
    checkOutput("t5_big_count", 32'(count), 32'd5);
    checkOutput("t5_big_ovf", 32'(overflow), 32'd0);
    applyStimulus(MODE_PLAYBACK, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_mem0", 32'(pattern_leds4), 32'h1);
    applyStimulus(MODE_PLAYBACK, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_mem1", 32'(pattern_leds4), 32'h2);
    applyStimulus(MODE_PLAYBACK, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_mem2", 32'(pattern_leds4), 32'h4);
    applyStimulus(MODE_PLAYBACK, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_mem3", 32'(pattern_leds4), 32'h8);
    checkOutput("t5_play_eq", 32'(play_eq_count4), 32'd1);
    applyStimulus(MODE_IDLE, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_clr_ovf", 32'(overflow4), 32'd0);
    checkOutput("t5_clr_count", 32'(count4), 32'd0);
    checkOutput("t5_clr_full", 32'(seq_full4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
